uart_tx_sequencer: RTL and testbench

Memory-mapped controller between the core's store path and the UART transmit buffer.
- Decodes CPU stores to a TX data address and queues the bytes in an internal FIFO.
- Issues bytes one at a time to the UART using a start/ready handshake.
- Exposes a status word the core reads at a status address.
- Replaces the direct MemWrite-to-UART connection, so stores to unrelated addresses no longer emit bytes.

---
 rtl/uart_tx_sequencer_pkg.sv | 33 +++
 rtl/sync_fifo_8.sv | 54 +++++
 rtl/uart_tx_sequencer.sv | 105 ++++++++++
 tb/tb_uart_tx_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sequencer_pkg.sv
// Shared definitions for the UART transmit sequencer: FSM encoding, status word
// layout and the default decode addresses.
package uart_tx_sequencer_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_W   = 8;

  localparam logic [31:0] DEF_TX_ADDR   = 32'h0000_0100;
  localparam logic [31:0] DEF_STAT_ADDR = 32'h0000_0104;

  function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                              input logic busy, input logic ovf,
                                              input logic [STAT_COUNT_W-1:0] count);
    logic [31:0] w;
    w = '0;
    w[STAT_EMPTY] = empty;
    w[STAT_FULL]  = full;
    w[STAT_BUSY]  = busy;
    w[STAT_OVF]   = ovf;
    w[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo_8.sv
// Byte-wide synchronous FIFO; DEPTH must be a power of two so the pointers wrap
// naturally. Push on full and pop on empty are ignored.
module sync_fifo_8 #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               data,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (!areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Memory-mapped bridge from CPU stores to the UART: queues bytes written to
// TX_ADDR and hands them out one at a time with a start/ready handshake.
module uart_tx_sequencer
  import uart_tx_sequencer_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] TX_ADDR     = DEF_TX_ADDR,
  parameter logic [31:0] STAT_ADDR   = DEF_STAT_ADDR,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          overflow;
  logic          tx_store;
  logic          ovf_clear;
  logic          pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_wdata;

  assign tx_store     = we && (addr == TX_ADDR);
  assign ovf_clear    = we && (addr == STAT_ADDR) && wdata[3];
  assign pop          = (state == ST_WAIT_ACK) && !tx_ready;
  assign unused_wdata = ^wdata[31:8];

  assign hit   = (addr == STAT_ADDR);
  assign rdata = hit ? pack_status(fifo_empty, fifo_full, state != ST_IDLE, overflow,
                                   STAT_COUNT_W'(fifo_count))
                     : '0;

  // The FIFO sees the pre-edge full flag, so a push onto a full queue is dropped
  // even when the same edge pops.
  sync_fifo_8 #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .areset (areset),
    .push   (tx_store),
    .pop    (pop),
    .data   (wdata[7:0]),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!areset) begin
      state    <= ST_IDLE;
      timer    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty && tx_ready) begin
            tx_data  <= fifo_head;
            tx_start <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // Ready dropping is the UART's acceptance; staying ready too long re-issues.
          if (!tx_ready) begin
            state <= ST_WAIT_DONE;
          end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
            tx_start <= 1'b1;
            state    <= ST_ISSUE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (tx_store && fifo_full) overflow <= 1'b1;
      else if (ovf_clear)        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: queue-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_sequencer;

  localparam int          DEPTH       = 16;
  localparam int          ACK_TIMEOUT = 255;
  localparam logic [31:0] TX_A        = 32'h0000_0100;
  localparam logic [31:0] ST_A        = 32'h0000_0104;

  logic        clk      = 1'b0;
  logic        areset   = 1'b0;
  logic        we       = 1'b0;
  logic [31:0] addr     = '0;
  logic [31:0] wdata    = '0;
  logic        tx_ready = 1'b1;
  logic [31:0] rdata;
  logic        hit;
  logic        tx_start;
  logic [7:0]  tx_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_sequencer #(
    .DEPTH(DEPTH), .TX_ADDR(TX_A), .STAT_ADDR(ST_A), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .areset(areset), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .hit(hit), .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, sticky overflow, and whether a
  // pulsed byte is still awaiting acceptance.
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_out;
  bit         prev_start;
  bit         chk_en = 1'b0;

  always @(negedge clk) begin : model
    logic [31:0] exp_stat;
    bit push_req, clr, pop_now, full_pre;
    if (chk_en) begin
      exp_stat = {20'b0, 8'(mq.size()), m_ovf, 1'b0, mq.size() == DEPTH, mq.size() == 0};
      check("hit", 32'(hit), 32'(addr == ST_A));
      check("status", rdata & ~32'h4, (addr == ST_A) ? exp_stat : 32'h0);
      if (tx_start === 1'b1) begin
        check("start_width", 32'(prev_start), 32'h0);
        check("start_nonempty", 32'(mq.size() != 0), 32'h1);
        if (mq.size() != 0) check("tx_data", 32'(tx_data), 32'(mq[0]));
      end
    end
    if (!areset) begin
      mq.delete();
      m_ovf      = 1'b0;
      m_out      = 1'b0;
      prev_start = 1'b0;
      chk_en     = 1'b1;
    end else begin
      push_req = we && (addr == TX_A);
      clr      = we && (addr == ST_A) && wdata[3];
      pop_now  = m_out && !tx_start && !tx_ready;
      full_pre = (mq.size() == DEPTH);
      if (pop_now) begin
        if (mq.size() != 0) void'(mq.pop_front());
        m_out = 1'b0;
      end
      if (tx_start) m_out = 1'b1;
      if (push_req) begin
        if (full_pre) m_ovf = 1'b1;
        else          mq.push_back(wdata[7:0]);
      end else if (clr) begin
        m_ovf = 1'b0;
      end
      prev_start = tx_start;
    end
  end

  // UART responder and pulse log, all driven from the main process.
  logic [7:0] got[$];
  time        got_t[$];
  bit         uart_auto = 1'b0;
  int         ua_phase  = 0;
  int         ua_ctr    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic uart_step(input logic seen);
    if (seen) begin
      ua_phase = 1;
      ua_ctr   = $urandom_range(0, 2);
    end
    case (ua_phase)
      1: if (ua_ctr == 0) begin
           tx_ready = 1'b0;
           ua_phase = 2;
           ua_ctr   = $urandom_range(1, 3);
         end else ua_ctr--;
      2: begin
           ua_ctr--;
           if (ua_ctr == 0) begin
             tx_ready = 1'b1;
             ua_phase = 0;
           end
         end
      default: ;
    endcase
  endtask

  task automatic cycle();
    logic s;
    @(negedge clk);
    s = tx_start;
    if (tx_start === 1'b1) begin
      got.push_back(tx_data);
      got_t.push_back($time);
    end
    @(posedge clk);
    #1;
    if (uart_auto) uart_step(s);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    cycle();
    we = 1'b0; addr = ST_A;
  endtask

  task automatic read_stat(input string name, input logic [31:0] exp);
    we = 1'b0; addr = ST_A;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      cycle();
      k++;
    end
  endtask

  task automatic start_auto();
    ua_phase = 0; tx_ready = 1'b1; uart_auto = 1'b1;
  endtask

  initial begin
    logic seen;
    int   n;

    // Reset then one byte with the documented latency.
    tick(); tick();
    areset = 1'b1;
    read_stat("reset_stat", 32'h1);
    check("reset_start", 32'(tx_start), 32'h0);
    check("reset_data", 32'(tx_data), 32'h0);
    we = 1'b1; addr = TX_A; wdata = 32'h41;
    tick();
    we = 1'b0; addr = ST_A;
    check("lat_n1", 32'(tx_start), 32'h0);
    tick();
    check("lat_n2", 32'(tx_start), 32'h1);
    check("lat_data", 32'(tx_data), 32'h41);
    tick();
    check("pulse_1cyc", 32'(tx_start), 32'h0);
    tx_ready = 1'b0; tick();
    tx_ready = 1'b1; tick();
    read_stat("t1_empty", 32'h1);
    check("t1_hold", 32'(tx_data), 32'h41);

    // Store to an unrelated address.
    we = 1'b1; addr = 32'h200; wdata = 32'h55;
    tick();
    we = 1'b0;
    #1;
    check("t2_hit", 32'(hit), 32'h0);
    check("t2_rdata", rdata, 32'h0);
    seen = 1'b0;
    repeat (4) begin tick(); seen |= tx_start; end
    check("t2_nostart", 32'(seen), 32'h0);
    read_stat("t2_stat", 32'h1);

    // Overflow, clear, then drain in order.
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) store(TX_A, 32'(i));
    read_stat("t3_full_ovf", 32'h0000_010A);
    store(ST_A, 32'h8);
    read_stat("t3_clr", 32'h0000_0102);
    got.delete(); got_t.delete();
    start_auto();
    wait_pulses(16, 400);
    repeat (40) cycle();
    check("t3_count", got.size(), 16);
    for (int i = 0; i < got.size() && i < 16; i++) check("t3_order", 32'(got[i]), 32'(i));
    read_stat("t3_drained", 32'h1);

    // Timeout re-issue, then a single acceptance.
    uart_auto = 1'b0; tx_ready = 1'b1;
    got.delete(); got_t.delete();
    store(TX_A, 32'hA5);
    store(TX_A, 32'h5A);
    wait_pulses(2, 600);
    check("t4_pulses", got.size(), 2);
    if (got.size() >= 2) begin
      check("t4_first", 32'(got[0]), 32'hA5);
      check("t4_again", 32'(got[1]), 32'hA5);
      check("t4_gap", 32'((got_t[1] - got_t[0]) / 10), ACK_TIMEOUT + 1);
    end
    tx_ready = 1'b0;
    repeat (3) cycle();
    read_stat("t4_one_pop", 32'h0000_0014);
    start_auto();
    wait_pulses(3, 50);
    check("t4_next_cnt", got.size(), 3);
    if (got.size() >= 3) check("t4_next", 32'(got[2]), 32'h5A);
    repeat (30) cycle();
    read_stat("t4_drained", 32'h1);

    // Push on the same edge as the acceptance pop.
    uart_auto = 1'b0; tx_ready = 1'b0;
    got.delete(); got_t.delete();
    store(TX_A, 32'hB1); store(TX_A, 32'hB2); store(TX_A, 32'hB3);
    tx_ready = 1'b1;
    wait_pulses(1, 10);
    tx_ready = 1'b0; we = 1'b1; addr = TX_A; wdata = 32'hB4;
    cycle();
    we = 1'b0; addr = ST_A;
    read_stat("t5_count", 32'h0000_0034);
    start_auto();
    wait_pulses(4, 100);
    check("t5_cnt", got.size(), 4);
    if (got.size() >= 4) begin
      check("t5_b1", 32'(got[0]), 32'hB1);
      check("t5_b2", 32'(got[1]), 32'hB2);
      check("t5_b3", 32'(got[2]), 32'hB3);
      check("t5_b4", 32'(got[3]), 32'hB4);
    end
    repeat (30) cycle();

    // Reset while waiting for the UART to finish.
    uart_auto = 1'b0; tx_ready = 1'b0;
    got.delete(); got_t.delete();
    for (int i = 0; i < 6; i++) store(TX_A, 32'h60 + 32'(i));
    tx_ready = 1'b1;
    wait_pulses(1, 10);
    tx_ready = 1'b0;
    cycle(); cycle();
    read_stat("t6_pre", 32'h0000_0054);
    areset = 1'b0;
    cycle();
    areset = 1'b1;
    check("t6_start", 32'(tx_start), 32'h0);
    read_stat("t6_reset", 32'h1);
    tx_ready = 1'b1;
    n = got.size();
    repeat (20) cycle();
    check("t6_no_pulse", got.size(), n);

    // Randomised traffic against the model.
    start_auto();
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 35) begin
        we = 1'b1; addr = TX_A; wdata = $urandom;
      end else if (r < 40) begin
        we = 1'b1; addr = ST_A; wdata = $urandom;
      end else if (r < 44) begin
        we = 1'b1; addr = 32'h200 + 32'($urandom_range(0, 15) * 4); wdata = $urandom;
      end else begin
        we = 1'b0; addr = (r < 85) ? ST_A : $urandom;
      end
      if ($urandom_range(0, 499) == 0) areset = 1'b0;
      cycle();
      areset = 1'b1;
      we = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
